// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle front end for the combinational 32-bit ALU. A request is
// registered onto the ALU inputs, held for an opcode-dependent settle time,
// and the 64-bit result is returned on a response handshake. Opcodes the ALU
// does not compute and division by zero are answered immediately without
// ever presenting them to the ALU.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. req_ready is high only in IDLE. rsp_valid is high only in
// RESP, and every rsp_* / alu_* output is held constant while rsp_valid is
// high and rsp_ready is low. Requests are never queued.

module alu_op_sequencer #(
   parameter int unsigned ALU_LAT    = 1,   // EXEC cycles for single-cycle ops (1..15)
   parameter int unsigned MULDIV_LAT = 4    // EXEC cycles for mul/div (1..15)
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_y,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_opcode,
   input  logic [63:0] alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_lo,
   output logic [31:0] rsp_hi,
   output logic        rsp_hilo_we,
   output logic        rsp_dz,
   output logic        rsp_illegal,
   output logic [15:0] op_count,
   output logic [1:0]  dbg_state       // current FSM state, for debug/checkers
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [4:0] OP_NOP = 5'b11001;
   localparam logic [4:0] OP_MUL = 5'b01110;
   localparam logic [4:0] OP_DIV = 5'b01111;

   // Counter preload values: EXEC lasts LAT cycles, last one seen at count 0.
   localparam logic [3:0] ALU_CNT    = 4'(ALU_LAT - 1);
   localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic        r_muldiv;

   logic        w_accept;
   logic        w_legal;
   logic        w_muldiv;
   logic        w_div0;
   logic        w_cnt_zero;

   // The ALU computes opcodes 00011 through 10001 inclusive; nothing else.
   assign w_legal    = (req_opcode >= 5'b00011) && (req_opcode <= 5'b10001);
   assign w_muldiv   = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
   assign w_div0     = (req_opcode == OP_DIV) && (req_b == 32'd0);
   assign w_accept   = req_valid && req_ready;
   assign w_cnt_zero = (r_cnt == 4'd0);
   assign dbg_state  = r_state;

   // State register.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and handshake outputs decoded from the state.
   always_comb begin
      w_next_state = r_state;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (w_accept) begin
               if (!w_legal || w_div0) begin
                  w_next_state = ST_RESP;
               end else begin
                  w_next_state = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (w_cnt_zero) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, settle counter, result capture and op count.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         alu_y       <= 32'd0;
         alu_b       <= 32'd0;
         alu_opcode  <= OP_NOP;
         r_cnt       <= 4'd0;
         r_muldiv    <= 1'b0;
         rsp_lo      <= 32'd0;
         rsp_hi      <= 32'd0;
         rsp_hilo_we <= 1'b0;
         rsp_dz      <= 1'b0;
         rsp_illegal <= 1'b0;
         op_count    <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  alu_y       <= req_a;
                  alu_b       <= req_b;
                  r_muldiv    <= w_muldiv;
                  rsp_lo      <= 32'd0;
                  rsp_hi      <= 32'd0;
                  rsp_hilo_we <= 1'b0;
                  rsp_dz      <= 1'b0;
                  rsp_illegal <= 1'b0;
                  if (!w_legal) begin
                     // Never hand an unknown opcode to the ALU.
                     alu_opcode  <= OP_NOP;
                     rsp_illegal <= 1'b1;
                  end else if (w_div0) begin
                     // HI/LO still written (with zeros) so software sees a defined result.
                     alu_opcode  <= OP_NOP;
                     rsp_dz      <= 1'b1;
                     rsp_hilo_we <= 1'b1;
                  end else begin
                     alu_opcode <= req_opcode;
                     r_cnt      <= w_muldiv ? MULDIV_CNT : ALU_CNT;
                  end
               end
            end
            ST_EXEC: begin
               if (w_cnt_zero) begin
                  rsp_lo      <= alu_c[31:0];
                  rsp_hi      <= r_muldiv ? alu_c[63:32] : 32'd0;
                  rsp_hilo_we <= r_muldiv;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  op_count <= op_count + 16'd1;
               end
            end
            default: begin
               r_cnt <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle sequencer in front of the combinational 32-bit ALU.
- Accepts one operation per request handshake and registers the operands and opcode onto the ALU inputs.
- Waits an opcode-dependent settle time, then captures the 64-bit ALU result and returns it on a response handshake.
- Sits between the control unit and the ALU and replaces direct Y/Z register strobing.
- Screens out opcodes the ALU does not compute, and division by zero.

Parameters:
ALU_LAT, 1, EXEC cycles for single-cycle ALU ops (legal 1..15)
MULDIV_LAT, 4, EXEC cycles for mul (5'b01110) and div (5'b01111) (legal 1..15)

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  sequencer can accept a request
req_opcode  in  5  ALU opcode
req_a  in  32  operand A, drives ALU Y input
req_b  in  32  operand B, drives ALU B input
alu_y  out  32  to ALU Y input
alu_b  out  32  to ALU B input
alu_opcode  out  5  to ALU opcode input
alu_c  in  64  ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_lo  out  32  result bits [31:0]
rsp_hi  out  32  result bits [63:32]; mul/div only
rsp_hilo_we  out  1  HI/LO write enable, set for mul/div
rsp_dz  out  1  divide-by-zero flag
rsp_illegal  out  1  opcode not an ALU operation
op_count  out  16  completed responses, wraps

Behaviour:
- Single clock; reset is asynchronous and active-low (clear_n).
- Reset values:
  - State IDLE, counter 0.
  - alu_y = 0, alu_b = 0, alu_opcode = 5'b11001 (nop).
  - All rsp_* = 0, op_count = 0, req_ready = 1.
- Reset during any state aborts the operation. No response is produced for it.
- Legal opcodes: 00011, 00100, 00101, 00110, 00111, 01000, 01001, 01010, 01011, 01100, 01101, 01110, 01111, 10000, 10001. All other opcodes are illegal.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 1 (high only in IDLE).
  - On req_valid & req_ready, register req_a, req_b and req_opcode onto alu_y, alu_b and alu_opcode.
  - Illegal opcode: go to RESP with rsp_illegal = 1 and rsp_lo/rsp_hi = 0. alu_opcode stays nop.
  - Opcode 01111 with req_b == 0: go to RESP with rsp_dz = 1, rsp_lo/rsp_hi = 0, rsp_hilo_we = 1.
  - Otherwise: load the counter with LAT-1 and go to EXEC. LAT = MULDIV_LAT for 01110/01111, else ALU_LAT.
- EXEC:
  - ALU inputs held stable; the counter decrements every cycle.
  - At the edge where the counter is 0:
    - rsp_lo <= alu_c[31:0].
    - rsp_hi <= alu_c[63:32] for mul/div, else 0.
    - rsp_hilo_we <= 1 for mul/div, else 0.
    - Go to RESP.
- Latency: the accept edge is cycle 0. rsp_valid rises after cycle LAT (ALU_LAT=1 gives 2 edges after accept). Error cases give rsp_valid after cycle 0.
- RESP:
  - rsp_valid = 1; all rsp_* and alu_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready: op_count increments (0xFFFF wraps to 0x0000), rsp_valid drops, and the state returns to IDLE.
  - A new request cannot be accepted in the same cycle (minimum 1 IDLE cycle between operations).
- req_valid is ignored outside IDLE. Requests are never queued.
- rsp_* flags are cleared on entry to EXEC or to an error RESP. They are never sticky across operations.
- alu_y, alu_b and alu_opcode keep the last operation's values in IDLE.

Test Plan:
- Add: req_opcode=00011, a=5, b=7, rsp_ready=1 -> rsp_valid exactly 2 edges after accept; rsp_lo=12, rsp_hi=0, rsp_hilo_we=0; op_count=1.
- Mul: opcode=01110, a=b=0x00010000, MULDIV_LAT=4 -> alu_opcode=01110 for cycles 1..4; rsp_valid 5 edges after accept; {hi,lo}={0x00000001,0x00000000}; rsp_hilo_we=1.
- Div by zero: opcode=01111, a=100, b=0 -> rsp_valid 1 edge after accept; rsp_dz=1, rsp_lo=rsp_hi=0, rsp_hilo_we=1, alu_opcode never 01111.
- Illegal and backpressure: opcode=11010 with rsp_ready low 3 cycles and req_valid held high -> rsp_illegal=1 stable 3 cycles, req_ready=0 throughout; after rsp_ready the next request is accepted only after one IDLE cycle.
- Reset mid-op: div 0x64/0x5 accepted, clear_n low in EXEC cycle 2 -> immediately state IDLE, alu_opcode=11001, rsp_valid=0, op_count=0; no response after release.
- Wrap: force 65536 completions (or preload via 0xFFFF run) -> op_count returns to 0x0000.
